// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the alu_drv serial ALU initiator.
package alu_drv_pkg;

  localparam int unsigned ALU_DRV_DATA_WIDTH = 8;

  localparam logic [1:0] OPC_ADD  = 2'b00;
  localparam logic [1:0] OPC_SUB  = 2'b01;
  localparam logic [1:0] OPC_PAR  = 2'b10;
  localparam logic [1:0] OPC_COMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_A    = 3'd1,
    ST_SEND_B    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  typedef struct packed {
    logic overflow;
    logic timeout;
    logic mismatch;
  } rsp_flags_t;

  typedef struct packed {
    logic [ALU_DRV_DATA_WIDTH-1:0] result;
    rsp_flags_t                    flags;
  } rsp_t;

endpackage

// File: rtl/alu_drv_model.sv
// Combinational reference for the ALU result/overflow of a latched command.
module alu_drv_model
  import alu_drv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DRV_DATA_WIDTH
) (
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] exp_result_o,
  output logic                  exp_overflow_o
);

  logic [DATA_WIDTH:0]   sum_w;
  logic [DATA_WIDTH:0]   diff_w;
  logic [DATA_WIDTH-1:0] xor_w;

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};
  assign xor_w  = a_i ^ b_i;

  always_comb begin
    exp_result_o   = '0;
    exp_overflow_o = 1'b0;
    case (op_i)
      OPC_ADD: {exp_overflow_o, exp_result_o} = sum_w;
      OPC_SUB: {exp_overflow_o, exp_result_o} = diff_w;
      OPC_PAR: begin
        exp_result_o   = xor_w;
        exp_overflow_o = ^xor_w;
      end
      default: exp_result_o = ~xor_w;
    endcase
  end

endmodule

// File: rtl/alu_drv.sv
// Serial operand initiator for simple_alu: command in, two operand beats out, response back.
// Optional result self-check enabled by defining ALU_DRV_SELFCHECK_EN.
module alu_drv
  import alu_drv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = ALU_DRV_DATA_WIDTH,
  parameter int unsigned DONE_TIMEOUT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_data_a,
  input  logic [DATA_WIDTH-1:0] cmd_data_b,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic                  overflow,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic                  rsp_mismatch,
  output logic                  busy
);

  localparam int unsigned     CNT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_hi_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  accept, capture, expire;

  logic                  cmd_ready_q, busy_q, rsp_valid_q;
  logic                  opcode_valid_q, opcode_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_result_q;
  logic                  rsp_overflow_q, rsp_timeout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_d = ST_SEND_A;
      end
      ST_SEND_A: state_d = ST_SEND_B;
      ST_SEND_B: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          expire  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change exactly on state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_hi_q        <= 1'b0;
      b_q            <= '0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      opcode_valid_q <= 1'b0;
      opcode_q       <= 1'b0;
      data_q         <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= (state_d == ST_IDLE);
      busy_q         <= (state_d != ST_IDLE);
      rsp_valid_q    <= (state_d == ST_RESP);
      opcode_valid_q <= (state_d == ST_SEND_A) || (state_d == ST_SEND_B);
      if (accept) begin
        op_hi_q <= cmd_opcode[1];
        b_q     <= cmd_data_b;
      end
      case (state_d)
        ST_SEND_A: begin
          opcode_q <= cmd_opcode[0];
          data_q   <= cmd_data_a;
        end
        ST_SEND_B: begin
          opcode_q <= op_hi_q;
          data_q   <= b_q;
        end
        default: begin
          opcode_q <= 1'b0;
          data_q   <= '0;
        end
      endcase
      if (capture) begin
        rsp_result_q   <= result;
        rsp_overflow_q <= overflow;
        rsp_timeout_q  <= 1'b0;
      end else if (expire) begin
        rsp_result_q   <= '0;
        rsp_overflow_q <= 1'b0;
        rsp_timeout_q  <= 1'b1;
      end
    end
  end

`ifdef ALU_DRV_SELFCHECK_EN
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] exp_result;
  logic                  exp_overflow;
  logic                  rsp_mismatch_q;

  alu_drv_model #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_model (
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .exp_result_o  (exp_result),
    .exp_overflow_o(exp_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= '0;
      a_q            <= '0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_opcode;
        a_q  <= cmd_data_a;
      end
      if (capture) begin
        rsp_mismatch_q <= (result != exp_result) || (overflow != exp_overflow);
`ifndef SYNTHESIS
        if ((result != exp_result) || (overflow != exp_overflow))
          $display("alu_drv error @%0t: op=%0d a=%0h b=%0h expected res=%0h ovf=%0b got res=%0h ovf=%0b",
                   $time, op_q, a_q, b_q, exp_result, exp_overflow, result, overflow);
`endif
      end else if (expire) begin
        rsp_mismatch_q <= 1'b0;
      end
    end
  end

  assign rsp_mismatch = rsp_mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign opcode_valid = opcode_valid_q;
  assign opcode       = opcode_q;
  assign data         = data_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_alu_drv.sv
// Directed scoreboard bench for alu_drv; a small ALU stub answers with per-step result/overflow.
module tb_alu_drv;

  localparam int unsigned DW  = 8;
  localparam int          DTO = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode = '0;
  logic [DW-1:0] cmd_data_a = '0;
  logic [DW-1:0] cmd_data_b = '0;
  logic          opcode_valid, opcode;
  logic [DW-1:0] data;
  logic          done = 1'b0;
  logic          overflow = 1'b0;
  logic [DW-1:0] result = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow, rsp_timeout, rsp_mismatch, busy;

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    logic          tmo;
    logic          mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_drv #(
    .DATA_WIDTH  (DW),
    .DONE_TIMEOUT(DTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_data_a  (cmd_data_a),
    .cmd_data_b  (cmd_data_b),
    .opcode_valid(opcode_valid),
    .opcode      (opcode),
    .data        (data),
    .done        (done),
    .overflow    (overflow),
    .result      (result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_timeout (rsp_timeout),
    .rsp_mismatch(rsp_mismatch),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ALU_DRV_SELFCHECK_EN
  function automatic logic [DW:0] ref_calc(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] x;
    x = a ^ b;
    case (op)
      2'b00:   ref_calc = {1'b0, a} + {1'b0, b};
      2'b01:   ref_calc = {1'b0, a} - {1'b0, b};
      2'b10:   ref_calc = {^x, x};
      default: ref_calc = {1'b0, ~x};
    endcase
  endfunction
`endif

  // Entered and left at a negedge with the DUT idle; done_at<0 means the stub never answers.
  task automatic run_txn(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int done_at, input logic [DW-1:0] alu_res, input logic alu_ovf,
                         input int hold, input logic early_rdy);
    exp_t e;
    int   wc;
    int   exp_wait;
    if (done_at >= 0 && done_at < DTO) begin
      e.res = alu_res;
      e.ovf = alu_ovf;
      e.tmo = 1'b0;
`ifdef ALU_DRV_SELFCHECK_EN
      e.mis = ({alu_ovf, alu_res} !== ref_calc(op, a, b));
`else
      e.mis = 1'b0;
`endif
      exp_wait = done_at + 1;
    end else begin
      e.res = '0;
      e.ovf = 1'b0;
      e.tmo = 1'b1;
      e.mis = 1'b0;
      exp_wait = DTO;
    end
    sb.push_back(e);

    check("idle_gap_opcode_valid", opcode_valid, 0);
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_data_a = a;
    cmd_data_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("send_a_beat", {busy, cmd_ready, opcode_valid, opcode, data},
          {1'b1, 1'b0, 1'b1, op[0], a});
    @(negedge clk);
    check("send_b_beat", {opcode_valid, opcode, data}, {1'b1, op[1], b});

    rsp_ready = early_rdy;
    wc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done = 1'b0;
      if (rsp_valid) break;
      wc++;
      check("wait_quiet", {opcode_valid, opcode, data}, '0);
      if (wc - 1 == done_at) begin
        done     = 1'b1;
        result   = alu_res;
        overflow = alu_ovf;
      end
    end
    check("wait_cycles", wc, exp_wait);

    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      for (int h = 0; h <= hold; h++) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_cmd_ready", cmd_ready, 0);
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", {rsp_overflow, rsp_timeout, rsp_mismatch}, {e.ovf, e.tmo, e.mis});
        if (h < hold) @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("back_to_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_outputs", {opcode_valid, opcode, data, rsp_valid, rsp_result,
                            rsp_overflow, rsp_timeout, rsp_mismatch, busy}, '0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(2'b00, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 0, 1'b0);
    run_txn(2'b01, 8'h05, 8'h07, 0, 8'hFE, 1'b1, 0, 1'b0);
    run_txn(2'b11, 8'hA5, 8'h0F, 0, 8'h55, 1'b0, 0, 1'b1);
    run_txn(2'b10, 8'hA5, 8'h0F, 0, 8'hAA, 1'b1, 0, 1'b0);
    run_txn(2'b00, 8'h11, 8'h22, -1, 8'h00, 1'b0, 0, 1'b0);
    run_txn(2'b01, 8'h30, 8'h10, 1, 8'h20, 1'b0, 5, 1'b0);

    // Reset lands while SEND_B is on the bus; a late done must not revive the transaction.
    cmd_valid  = 1'b1;
    cmd_opcode = 2'b00;
    cmd_data_a = 8'h12;
    cmd_data_b = 8'h34;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_send_b", {opcode_valid, data}, {1'b1, 8'h34});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_state", {opcode_valid, busy, cmd_ready, rsp_valid, data}, {4'b0010, 8'h00});
    done     = 1'b1;
    result   = 8'h77;
    overflow = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("late_done_ignored", {rsp_valid, busy, rsp_result, rsp_overflow}, '0);
    @(negedge clk);
    check("late_done_still_idle", {rsp_valid, busy, cmd_ready}, 3'b001);

    run_txn(2'b00, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_drv.md
Name: alu_drv

Overview:
- Transaction-level initiator for the simple_alu serial operand interface.
- Accepts one command (2-bit opcode, two operands) on a valid/ready port and serializes it onto opcode_valid/opcode/data.
- Waits for done, captures result/overflow, and returns a response on a valid/ready port.
- Sits between testbench sequencers (or a host block) and the ALU; it is the driving end of the interface the ALU checker monitors.

Parameters:
- DATA_WIDTH, 8, operand/result width.
- DONE_TIMEOUT, 2, maximum WAIT_DONE cycles allowed for done; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_opcode  in  2  00 ADD, 01 SUB, 10 PAR, 11 COMP.
- cmd_data_a  in  DATA_WIDTH  first operand.
- cmd_data_b  in  DATA_WIDTH  second operand.
- opcode_valid  out  1  to ALU.
- opcode  out  1  serial opcode bit to ALU.
- data  out  DATA_WIDTH  operand to ALU.
- done  in  1  from ALU.
- overflow  in  1  from ALU.
- result  in  DATA_WIDTH  from ALU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_result  out  DATA_WIDTH  captured result.
- rsp_overflow  out  1  captured overflow.
- rsp_timeout  out  1  done not seen within DONE_TIMEOUT.
- rsp_mismatch  out  1  self-check failure (see Optional Feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=1 at a posedge): state IDLE; every output 0 except cmd_ready=1. Reset overrides all else; mid-transaction it drops the pending command and response, and opcode_valid is 0 from the next cycle.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_DONE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch opcode/operands and go to SEND_A.
- SEND_A (1 cycle): opcode_valid=1, opcode=op[0], data=A. Next state SEND_B.
- SEND_B (1 cycle): opcode_valid=1, opcode=op[1], data=B. Next state WAIT_DONE; clear wait counter.
- WAIT_DONE: opcode_valid=0, data=0, opcode=0.
  - Each cycle, sample done.
  - If done=1, capture result/overflow into rsp_*, set rsp_timeout=0, go to RESP.
  - Else increment the counter. After DONE_TIMEOUT cycles without done: rsp_result=0, rsp_overflow=0, rsp_timeout=1, go to RESP.
- RESP: rsp_valid=1, rsp_* stable. On rsp_ready, go to IDLE.
  - rsp_ready may already be high on entry: one-cycle RESP.
- Latency: cmd accepted at edge T; SEND_A during T..T+1, SEND_B during T+1..T+2; done earliest at the T+3 edge; rsp_valid earliest after T+3.
- Minimum one IDLE cycle between transactions, giving >=1 cycle of opcode_valid=0 between operand pairs.
- done outside WAIT_DONE is ignored. Only the first done in WAIT_DONE is used.
- Outputs are registered; data/opcode are 0 whenever opcode_valid=0 (never X/Z).
- Timeout counter width: $clog2(DONE_TIMEOUT+1).

Optional Feature:
- Macro: ALU_DRV_SELFCHECK_EN.
- Enabled: compute the expected value from the latched command:
  - ADD: {ovf,res}=A+B.
  - SUB: {ovf,res}=A-B (borrow).
  - PAR: res=A^B, ovf=^res.
  - COMP: res=A~^B, ovf=0.
  - On non-timeout capture, set rsp_mismatch=1 if result or overflow differs, and $display an error with time, opcode, operands, expected and actual values.
- Disabled: rsp_mismatch tied 0; no reference model logic.

Decomposition:
- Package alu_drv_pkg holds:
  - DATA_WIDTH default.
  - Opcode constants OPC_ADD/SUB/PAR/COMP.
  - State enum typedef.
  - Response struct typedef (result, overflow, timeout, mismatch).
- One natural sub-module: alu_drv_model, a combinational expected-result calculator instantiated only under ALU_DRV_SELFCHECK_EN.

Test Plan:
- ADD A=0xF0 B=0x20; ALU done 1 cycle after SEND_B with result 0x10, overflow 1 -> opcode_valid exactly 2 cycles (opcode 0,0; data F0,20); rsp_result=0x10, rsp_overflow=1, rsp_timeout=0, rsp_mismatch=0.
- SUB A=0x05 B=0x07, model returns 0xFE/1; then COMP A=0xA5 B=0x0F returns 0x55/0 -> responses match; opcode bits (1,0) then (1,1); >=1 idle cycle between the two transactions.
- PAR A=0xA5 B=0x0F; ALU returns 0xAA/1 -> with SELFCHECK_EN, rsp_mismatch=1 (expected ovf 0); without it, rsp_mismatch=0.
- done never asserted -> rsp_valid after exactly DONE_TIMEOUT=2 WAIT_DONE cycles; rsp_timeout=1, rsp_result=0.
- rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_* stable, cmd_ready=0 throughout; returns to IDLE one cycle after rsp_ready=1.
- reset=1 during SEND_B -> next cycle opcode_valid=0, busy=0, cmd_ready=1, rsp_valid=0; a late done is ignored.
